// File: rtl/game_timer_pkg.sv
// -----------------------------------------------------------------------------
// game_timer_pkg
// Shared definitions for the game round timer:
//   - game_state_e : 2-bit FSM state encoding (IDLE/RUN/PAUSE/DONE)
//   - TIME_W       : width of the seconds counter
//   - bin_to_bcd2  : splits a 0..99 binary value into {tens, ones} digits
// -----------------------------------------------------------------------------
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } game_state_e;

  localparam int TIME_W = 7;

  // Constant-divisor split done as a compare/subtract chain so synthesis
  // builds a small comparator ladder rather than a generic divider.
  // Input is bounded to 0..99 by the counter's legal range.
  function automatic logic [7:0] bin_to_bcd2(input logic [TIME_W-1:0] v);
    logic [3:0]        tens;
    logic [TIME_W-1:0] rem;
    logic              found;
    tens  = 4'd0;
    rem   = v;
    found = 1'b0;
    for (int i = 9; i >= 1; i--) begin
      if (!found && (v >= TIME_W'(i * 10))) begin
        tens  = 4'(i);
        rem   = v - TIME_W'(i * 10);
        found = 1'b1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/game_timer_sec_edge_det.sv
// -----------------------------------------------------------------------------
// sec_edge_det
// Two-stage register chain on the 1 Hz square wave; emits a one-cycle pulse
// for every rising edge of sig_in.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (clears both stages)
//   sig_in   : clk-synchronous 1 Hz square wave
//   tick_out : high for one cycle per rising edge of sig_in (d1 & ~d2)
// -----------------------------------------------------------------------------
module sec_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic tick_out
);

  logic d1_q, d1_d;
  logic d2_q, d2_d;

  always_comb begin
    d1_d = sig_in;
    d2_d = d1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign tick_out = d1_q & ~d2_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
// Countdown timer for a game round. A 1 Hz square wave is edge-detected into
// one-cycle ticks; in RUN each tick removes one second. Reaching zero moves to
// DONE and pulses time_up for one cycle.
//
// Parameters:
//   GAME_SECONDS : round length, 1..99
//   WARN_SECONDS : low-time threshold, 0..GAME_SECONDS
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   sec_in     : clk-synchronous 1 Hz square wave
//   start      : pulse, (re)starts the round from GAME_SECONDS
//   pause      : pulse, toggles RUN <-> PAUSE
//   time_left  : remaining seconds (registered)
//   bcd_tens/bcd_ones : decimal digits of time_left (combinational)
//   running    : high in RUN
//   time_up    : one-cycle pulse the cycle after expiry
//   warn       : low-time indicator
//   state      : current FSM state (game_state_e encoding)
//
// Build option: define GAME_TIMER_WARN_EN to enable the warn output; without
// it warn is tied to 0.
//
// Handshake: start and pause are plain single-cycle strobes with no ready;
// a strobe is consumed on the clock edge where it is high. Per-cycle priority
// is rst > start > pause > tick.
// -----------------------------------------------------------------------------
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int GAME_SECONDS = 60,
  parameter int WARN_SECONDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_in,
  input  logic              start,
  input  logic              pause,
  output logic [TIME_W-1:0] time_left,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones,
  output logic              running,
  output logic              time_up,
  output logic              warn,
  output logic [1:0]        state
);

  localparam logic [TIME_W-1:0] FULL_TIME = TIME_W'(GAME_SECONDS);

  logic tick;

  sec_edge_det u_sec_edge_det (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sec_in),
    .tick_out (tick)
  );

  game_state_e       state_q,     state_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic              time_up_q,   time_up_d;

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    time_up_d   = 1'b0;

    if (start) begin
      state_d     = ST_RUN;
      time_left_d = FULL_TIME;
    end else if (pause) begin
      // A tick arriving in the same cycle as pause is intentionally lost.
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end else if (state_q == ST_PAUSE) begin
        state_d = ST_RUN;
      end
    end else if (tick && (state_q == ST_RUN)) begin
      // <= 1 rather than == 1 so the counter can never wrap below zero.
      if (time_left_q > TIME_W'(1)) begin
        time_left_d = time_left_q - TIME_W'(1);
      end else begin
        time_left_d = '0;
        state_d     = ST_DONE;
        time_up_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      time_left_q <= FULL_TIME;
      time_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      time_up_q   <= time_up_d;
    end
  end

`ifdef GAME_TIMER_WARN_EN
  localparam logic [TIME_W-1:0] WARN_LIMIT = TIME_W'(WARN_SECONDS);

  logic warn_q, warn_d;

  // Computed from next-state values so warn changes on the same edge as
  // time_left.
  always_comb begin
    warn_d = 1'b0;
    if (((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
        (time_left_d <= WARN_LIMIT)) begin
      warn_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  logic [7:0] bcd_pair;

  always_comb begin
    bcd_pair = bin_to_bcd2(time_left_q);
  end

  assign time_left = time_left_q;
  assign bcd_tens  = bcd_pair[7:4];
  assign bcd_ones  = bcd_pair[3:0];
  assign running   = (state_q == ST_RUN);
  assign time_up   = time_up_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
module tb_game_timer_ctrl;

  localparam int GS = 5;
  localparam int WS = 2;
`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif
  localparam int W = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sec_in = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] time_left;
  logic [3:0] bcd_tens, bcd_ones;
  logic       running, time_up, warn;
  logic [1:0] state;

  game_timer_ctrl #(.GAME_SECONDS(GS), .WARN_SECONDS(WS)) dut (
    .clk       (clk),
    .rst       (rst),
    .sec_in    (sec_in),
    .start     (start),
    .pause     (pause),
    .time_left (time_left),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .running   (running),
    .time_up   (time_up),
    .warn      (warn),
    .state     (state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  // States are plain integers 0..3; the model tracks the last two sec_in
  // samples taken since reset and applies the priority rules directly.
  int m_state = 0;
  int m_left  = GS;
  bit m_up    = 0;
  bit m_warn  = 0;
  bit s_prev  = 0;
  bit s_last  = 0;
  bit m_valid = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    bit tk;
    logic [W-1:0] e;
    if (rst) begin
      m_state = 0; m_left = GS; m_up = 0; s_prev = 0; s_last = 0;
      m_valid = 1;
    end else if (m_valid) begin
      tk   = s_last && !s_prev;
      m_up = 0;
      if (start) begin
        m_state = 1; m_left = GS;
      end else if (pause) begin
        if (m_state == 1) m_state = 2;
        else if (m_state == 2) m_state = 1;
      end else if (tk && m_state == 1) begin
        if (m_left > 1) m_left = m_left - 1;
        else begin m_left = 0; m_state = 3; m_up = 1; end
      end
      s_prev = s_last;
      s_last = sec_in;
    end
    m_warn = WARN_ON && (m_state == 1 || m_state == 2) && (m_left <= WS);
    if (m_valid) begin
      e = {2'(m_state), 7'(m_left), 4'(m_left / 10), 4'(m_left % 10),
           (m_state == 1), m_up, m_warn};
      exp_q.push_back(e);
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("cmp_state",     32'(state),     32'(e[19:18]));
      cmp("cmp_time_left", 32'(time_left), 32'(e[17:11]));
      cmp("cmp_bcd_tens",  32'(bcd_tens),  32'(e[10:7]));
      cmp("cmp_bcd_ones",  32'(bcd_ones),  32'(e[6:3]));
      cmp("cmp_running",   32'(running),   32'(e[2]));
      cmp("cmp_time_up",   32'(time_up),   32'(e[1]));
      cmp("cmp_warn",      32'(warn),      32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  int phase = 0;
  bit last_rise = 0;

  task automatic drive(input bit s, input bit p, input bit r);
    bit nv;
    @(negedge clk);
    start = s; pause = p; rst = r;
    nv = (phase < 4);
    last_rise = nv && !sec_in;
    sec_in = nv;
    phase = (phase + 1) % 8;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise();
    int guard;
    guard = 0;
    do begin
      drive(0, 0, 0);
      guard++;
    end while (!last_rise && guard < 20);
    checks++;
    if (!last_rise) begin
      errors++;
      $display("FAIL wait_rise got=no_edge exp=edge within 20 cycles");
    end
  endtask

  // Each tick is consumed on the edge after the one that registers the rise.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      wait_rise();
      drive(0, 0, 0);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (3) drive(0, 0, 1);
    drive(0, 0, 0);
    settle();
    cmp("rst_state", 32'(state), 0);
    cmp("rst_left", 32'(time_left), 5);
    cmp("rst_up", 32'(time_up), 0);
    cmp("rst_running", 32'(running), 0);
    cmp("rst_warn", 32'(warn), 0);

    drive(0, 1, 0); settle();
    cmp("idle_pause_ignored", 32'(state), 0);

    // Start -> RUN at 5
    drive(1, 0, 0); settle();
    cmp("start_state", 32'(state), 1);
    cmp("start_left", 32'(time_left), 5);
    cmp("start_tens", 32'(bcd_tens), 0);
    cmp("start_ones", 32'(bcd_ones), 5);

    // Count down to expiry
    wait_ticks(1); settle(); cmp("cd_left4", 32'(time_left), 4);
    wait_ticks(1); settle(); cmp("cd_left3", 32'(time_left), 3);
    cmp("cd_warn3", 32'(warn), 0);
    wait_ticks(1); settle(); cmp("cd_left2", 32'(time_left), 2);
    cmp("cd_warn2", 32'(warn), 32'(WARN_ON));
    wait_ticks(1); settle(); cmp("cd_left1", 32'(time_left), 1);
    wait_ticks(1); settle();
    cmp("cd_left0", 32'(time_left), 0);
    cmp("cd_state_done", 32'(state), 3);
    cmp("cd_up_pulse", 32'(time_up), 1);
    cmp("cd_warn_done", 32'(warn), 0);
    drive(0, 0, 0); settle();
    cmp("cd_up_clear", 32'(time_up), 0);
    wait_ticks(1); settle();
    cmp("done_hold_left", 32'(time_left), 0);
    cmp("done_hold_state", 32'(state), 3);

    // Start in DONE
    drive(1, 0, 0); settle();
    cmp("restart_state", 32'(state), 1);
    cmp("restart_left", 32'(time_left), 5);

    // Pause coincident with tick at 4
    wait_ticks(1); settle();
    cmp("coinc_pre_left", 32'(time_left), 4);
    wait_rise();
    drive(0, 1, 0); settle();
    cmp("coinc_state", 32'(state), 2);
    cmp("coinc_left", 32'(time_left), 4);

    // Pause after two ticks, three edges in PAUSE, resume
    drive(1, 0, 0); settle();
    wait_ticks(2); settle();
    cmp("pz_left3", 32'(time_left), 3);
    drive(0, 1, 0); settle();
    cmp("pz_state", 32'(state), 2);
    cmp("pz_running", 32'(running), 0);
    wait_ticks(3); settle();
    cmp("pz_hold_left", 32'(time_left), 3);
    drive(0, 1, 0); settle();
    cmp("pz_resume_state", 32'(state), 1);
    wait_ticks(1); settle();
    cmp("pz_next_left", 32'(time_left), 2);

    // Reset mid-round at 3
    drive(1, 0, 0); settle();
    wait_ticks(2); settle();
    cmp("mid_left3", 32'(time_left), 3);
    drive(0, 0, 1); settle();
    cmp("mid_rst_state", 32'(state), 0);
    cmp("mid_rst_left", 32'(time_left), 5);
    cmp("mid_rst_up", 32'(time_up), 0);
    drive(1, 1, 1); settle();
    cmp("rst_priority", 32'(state), 0);

    // Randomized phase, checked each cycle by the scoreboard
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 299) == 0);
    end
    drive(0, 0, 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL have parameter GAME_SECONDS, default 60, the round length in seconds; legal range 1..99.
REQ-002 SHALL have parameter WARN_SECONDS, default 10, the low-time warning threshold; legal range 0..GAME_SECONDS.
REQ-003 SHALL use one clock and a synchronous active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port sec_in, input, 1 bit: divided 1 Hz square wave from sec_clk (cout), clk-synchronous.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that starts or restarts the round.
REQ-008 SHALL have port pause, input, 1 bit: single-cycle pulse that toggles RUN/PAUSE.
REQ-009 SHALL have port time_left, output, 7 bits: remaining seconds.
REQ-010 SHALL have ports bcd_tens and bcd_ones, output, 4 bits each: decimal digits of time_left.
REQ-011 SHALL have port running, output, 1 bit: high in RUN only.
REQ-012 SHALL have port time_up, output, 1 bit: one-cycle pulse at expiry.
REQ-013 SHALL have port warn, output, 1 bit: low-time indicator.
REQ-014 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-015 SHALL register sec_in into d1, then d1 into d2; tick = d1 & ~d2, one cycle per rising edge of sec_in.
REQ-016 SHALL implement states IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-017 SHALL apply per-cycle priority start > pause > tick.
REQ-018 SHALL, on start in any state, load time_left=GAME_SECONDS and enter RUN at the next edge.
REQ-019 SHALL, in RUN on tick with time_left>1, decrement time_left by 1 at the next edge.
REQ-020 SHALL, in RUN on tick with time_left==1, set time_left=0, enter DONE and assert time_up for exactly the following cycle.
REQ-021 SHALL move RUN->PAUSE and PAUSE->RUN on pause; a tick coincident with pause is dropped.
REQ-022 SHALL ignore ticks in IDLE, PAUSE and DONE, and ignore pause in IDLE and DONE.
REQ-023 SHALL hold time_left at 0 in DONE until start or rst; time_left never wraps below 0.
REQ-024 SHALL derive bcd_tens=time_left/10 and bcd_ones=time_left%10 combinationally from the registered counter, with zero latency relative to time_left.

Reset
REQ-025 SHALL, on rst at any clock edge including mid-round, set state=IDLE, time_left=GAME_SECONDS, time_up=0, running=0, warn=0, d1=d2=0.
REQ-026 SHALL give rst priority over start, pause and tick.

Configuration
REQ-027 SHALL, with macro GAME_TIMER_WARN_EN defined, drive warn=1 while state is RUN or PAUSE and time_left<=WARN_SECONDS, else 0, registered with time_left.
REQ-028 SHALL, without GAME_TIMER_WARN_EN, tie warn to constant 0 and synthesize no compare logic.

Structure
REQ-029 SHALL place the state encodings and the 2-bit state typedef in the shared package game_timer_pkg.
REQ-030 SHALL implement the d1/d2 tick logic in sub-module sec_edge_det (clk, rst, sig_in -> tick_out); the FSM and counter stay in game_timer_ctrl.

Verification (bench GAME_SECONDS=5, WARN_SECONDS=2, sec_in period 8 clk)
REQ-031 SHALL cover reset release then start -> state=1, time_left=5, bcd_tens=0, bcd_ones=5.
REQ-032 SHALL cover 5 sec_in rising edges in RUN -> time_left 4,3,2,1,0; time_up high for exactly 1 cycle; state=3; a 6th edge leaves time_left=0.
REQ-033 SHALL cover pause after 2 ticks, then 3 edges, then pause -> time_left stays 3 while in PAUSE; the next edge gives 2.
REQ-034 SHALL cover pause coincident with tick at time_left=4 -> state=2, time_left=4.
REQ-035 SHALL cover start in DONE, and rst asserted in RUN at time_left=3 -> start reloads 5 in RUN; rst gives IDLE, time_left=5, time_up=0.
REQ-036 SHALL cover GAME_TIMER_WARN_EN defined -> warn rises when time_left reaches 2 and stays low in DONE; with the macro undefined, warn stays 0 throughout.
